// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared constants and types for the stopwatch display receive path
package stopwatch_pkg;

    localparam int FRAME_BITS = 14;
    localparam int SEG_W      = 7;
    localparam int CNT_W      = 4;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } seg_rd_state_t;

endpackage

// File: rtl/seg_to_digit.sv
// rtl/seg_to_digit.sv - combinational seven-segment pattern to BCD digit decoder
//
// Ports:
//   seg   in  7  segment pattern {g,f,e,d,c,b,a}
//   digit out 4  decoded digit 0-9 (0 when invalid)
//   valid out 1  pattern is one of the ten legal digit patterns
module seg_to_digit
    import stopwatch_pkg::*;
(
    input  logic [SEG_W-1:0] seg,
    output logic [3:0]       digit,
    output logic             valid
);

    always_comb begin
        digit = 4'd0;
        valid = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_reader.sv
// rtl/seg_reader.sv - serial two-digit seven-segment frame reader with valid/ready result port
//
// Ports:
//   clk        in  1  system clock
//   nRst       in  1  asynchronous active-low reset
//   sframe     in  1  frame-start strobe, qualifies the first bit with sbit_valid
//   sbit_valid in  1  sdata carries a frame bit
//   sdata      in  1  serial frame data, MSB first
//   num        out 8  tens*10 + units, or ERR_VALUE for a bad pattern
//   num_err    out 1  at least one pattern was not a digit
//   num_valid  out 1  result held on num/num_err
//   num_ready  in  1  consumer accepts the result
//   overrun    out 1  one-cycle pulse when a frame start is dropped
module seg_reader
    import stopwatch_pkg::*;
#(
    parameter logic [7:0] ERR_VALUE = 8'hFF
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       sframe,
    input  logic       sbit_valid,
    input  logic       sdata,
    output logic [7:0] num,
    output logic       num_err,
    output logic       num_valid,
    input  logic       num_ready,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    seg_rd_state_t state_q, state_d;

    // Only the first 13 bits need storage: the 14th bit is taken straight
    // from sdata into the decoder, so the result registers one cycle after it.
    logic [FRAME_BITS-2:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [FRAME_BITS-1:0] frame_word;

    logic start;
    logic accept;
    logic load_first;
    logic shift_en;
    logic frame_done;
    logic drop;

    logic [3:0] tens_digit;
    logic [3:0] units_digit;
    logic       tens_ok;
    logic       units_ok;
    logic [7:0] num_calc;

    assign start      = sframe & sbit_valid;
    assign accept     = num_valid & num_ready;
    assign frame_word = {shift_q, sdata};

    seg_to_digit u_tens (
        .seg   (frame_word[FRAME_BITS-1:SEG_W]),
        .digit (tens_digit),
        .valid (tens_ok)
    );

    seg_to_digit u_units (
        .seg   (frame_word[SEG_W-1:0]),
        .digit (units_digit),
        .valid (units_ok)
    );

    assign num_calc = ({4'd0, tens_digit} * 8'd10) + {4'd0, units_digit};

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        shift_en   = 1'b0;
        frame_done = 1'b0;
        drop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_first = 1'b1;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                // A new start mid-frame silently restarts the frame
                if (start) begin
                    load_first = 1'b1;
                end else if (sbit_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        frame_done = 1'b1;
                        state_d    = HOLD;
                    end
                end
            end
            HOLD: begin
                // A start coinciding with the handshake is not an overrun
                if (accept) begin
                    if (start) begin
                        load_first = 1'b1;
                        state_d    = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (start) begin
                    drop = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            num       <= 8'd0;
            num_err   <= 1'b0;
            num_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= drop;

            if (load_first) begin
                shift_q <= {{(FRAME_BITS-2){1'b0}}, sdata};
                cnt_q   <= CNT_W'(1);
            end else if (shift_en) begin
                shift_q <= frame_word[FRAME_BITS-2:0];
                cnt_q   <= cnt_q + CNT_W'(1);
            end

            if (frame_done) begin
                num_valid <= 1'b1;
                if (tens_ok && units_ok) begin
                    num     <= num_calc;
                    num_err <= 1'b0;
                end else begin
                    num     <= ERR_VALUE;
                    num_err <= 1'b1;
                end
            end else if (accept) begin
                num_valid <= 1'b0;
            end
        end
    end

endmodule
